// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - control word layout, bubble constant, ALUOp and opcode encodings
//
// Purpose: shared definitions for the control pipeline. The packed control word
//   is {RegDst,ALUSrc,MemtoReg,RegWrite,MemWrite,Branch,Jump,ExtOp,MemRead,ALUOp[1:0]}.
// Ports: none (package).
package ctrl_pkg;

   localparam int CTRL_W = 11;

   localparam int B_REGDST   = 10;
   localparam int B_ALUSRC   = 9;
   localparam int B_MEMTOREG = 8;
   localparam int B_REGWRITE = 7;
   localparam int B_MEMWRITE = 6;
   localparam int B_BRANCH   = 5;
   localparam int B_JUMP     = 4;
   localparam int B_EXTOP    = 3;
   localparam int B_MEMREAD  = 2;
   localparam int B_ALUOP_HI = 1;
   localparam int B_ALUOP_LO = 0;

   typedef enum logic [1:0] {
      ALUOP_RTYPE = 2'b00,
      ALUOP_ADD   = 2'b01,
      ALUOP_SUB   = 2'b10
   } aluop_e;

   // A bubble writes nothing, touches no memory and asks the ALU for a plain add.
   localparam logic [CTRL_W-1:0] BUBBLE = 11'b000_0000_0001;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   // Operand-select encodings for fwd_a / fwd_b.
   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational stall and operand-forwarding decisions
//
// Purpose: decides whether the instruction in ID must wait, and where the EX
//   instruction's ALU operands come from. Behaviour selected by CTRL_FWD_EN:
//   defined   -> stall on load-use only, forward from EX/MEM then MEM/WB;
//   undefined -> no forwarding, stall on any pending EX or MEM writer.
// Ports:
//   id_*   in   validity, operand-use flags and rs/rt of the ID instruction
//   ex_*   in   EX write/read flags, destination and sources
//   mem_*  in   MEM write flag and destination
//   wb_*   in   WB write flag and destination
//   stall  out  raw hazard stall (branch override applied by the caller)
//   fwd_a  out  ALU A select (00 regfile, 10 EX/MEM, 01 MEM/WB)
//   fwd_b  out  ALU B select, same encoding
module hazard_detect
   import ctrl_pkg::*;
#(
   parameter int RA_W = 5
) (
   input  logic            id_valid,
   input  logic            id_jump,
   input  logic            id_alusrc,
   input  logic            id_memwrite,
   input  logic            id_branch,
   input  logic [RA_W-1:0] id_rs,
   input  logic [RA_W-1:0] id_rt,
   input  logic            ex_regwrite,
   input  logic            ex_memread,
   input  logic [RA_W-1:0] ex_dst,
   input  logic [RA_W-1:0] ex_rs,
   input  logic [RA_W-1:0] ex_rt,
   input  logic            mem_regwrite,
   input  logic [RA_W-1:0] mem_dst,
   input  logic            wb_regwrite,
   input  logic [RA_W-1:0] wb_dst,
   output logic            stall,
   output logic [1:0]      fwd_a,
   output logic [1:0]      fwd_b
);

   logic uses_rs;
   logic uses_rt;

   // An invalid ID slot reads nothing, so it can never cause a stall.
   assign uses_rs = id_valid & ~id_jump;
   assign uses_rt = id_valid & (~id_alusrc | id_memwrite | id_branch);

   // Register $0 is hardwired, so it is never a real dependency.
   function automatic logic reads_dst(input logic [RA_W-1:0] dst,
                                      input logic [RA_W-1:0] rs,
                                      input logic [RA_W-1:0] rt,
                                      input logic            use_rs,
                                      input logic            use_rt);
      return (dst != '0) && ((use_rs && (dst == rs)) || (use_rt && (dst == rt)));
   endfunction

   function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] src,
                                          input logic            m_we,
                                          input logic [RA_W-1:0] m_dst,
                                          input logic            w_we,
                                          input logic [RA_W-1:0] w_dst);
      if (m_we && (m_dst != '0) && (m_dst == src)) return FWD_MEM;
      if (w_we && (w_dst != '0) && (w_dst == src)) return FWD_WB;
      return FWD_RF;
   endfunction

`ifdef CTRL_FWD_EN
   logic unused_fwd_inputs;
   assign unused_fwd_inputs = ex_regwrite;

   always_comb begin
      stall = 1'b0;
      fwd_a = FWD_RF;
      fwd_b = FWD_RF;
      // Only a load still in EX is too late to forward from.
      stall = ex_memread & reads_dst(ex_dst, id_rs, id_rt, uses_rs, uses_rt);
      fwd_a = fwd_sel(ex_rs, mem_regwrite, mem_dst, wb_regwrite, wb_dst);
      fwd_b = fwd_sel(ex_rt, mem_regwrite, mem_dst, wb_regwrite, wb_dst);
   end
`else
   logic unused_fwd_inputs;
   assign unused_fwd_inputs = ^{ex_memread, ex_rs, ex_rt, wb_regwrite, wb_dst};

   always_comb begin
      stall = 1'b0;
      fwd_a = FWD_RF;
      fwd_b = FWD_RF;
      // WB is not checked: the regfile writes before it reads.
      stall = (ex_regwrite  & reads_dst(ex_dst,  id_rs, id_rt, uses_rs, uses_rt)) |
              (mem_regwrite & reads_dst(mem_dst, id_rs, id_rt, uses_rs, uses_rt));
   end
`endif

endmodule

// File: rtl/ctrl_pipeline.sv
// rtl/ctrl_pipeline.sv - ID->EX->MEM->WB control pipeline with hazard control
//
// Purpose: carries the decoded control word and destination tags through the
//   ID/EX, EX/MEM and MEM/WB registers, and drives stall / IF-ID flush and the
//   ALU operand selects. Forwarding is built when CTRL_FWD_EN is defined.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   id_valid/id_ctrl     decoded instruction in ID (id_valid=0 -> bubble)
//   id_rs/id_rt/id_rd    register fields of the ID instruction
//   ex_zero              ALU zero flag in EX
//   ex_ctrl/mem_ctrl/wb_ctrl  stage control registers
//   ex_rs/ex_rt          ID/EX source tags
//   mem_dst/wb_dst       destination tags in MEM and WB
//   stall/flush_ifid     hold PC+IF/ID; zero IF/ID on next edge
//   fwd_a/fwd_b          ALU operand selects
module ctrl_pipeline
   import ctrl_pkg::*;
#(
   parameter int RA_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic [RA_W-1:0]   id_rs,
   input  logic [RA_W-1:0]   id_rt,
   input  logic [RA_W-1:0]   id_rd,
   input  logic              ex_zero,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic [CTRL_W-1:0] mem_ctrl,
   output logic [CTRL_W-1:0] wb_ctrl,
   output logic [RA_W-1:0]   ex_rs,
   output logic [RA_W-1:0]   ex_rt,
   output logic [RA_W-1:0]   mem_dst,
   output logic [RA_W-1:0]   wb_dst,
   output logic              stall,
   output logic              flush_ifid,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b
);

   logic [CTRL_W-1:0] ex_ctrl_q,  ex_ctrl_d;
   logic [CTRL_W-1:0] mem_ctrl_q, mem_ctrl_d;
   logic [CTRL_W-1:0] wb_ctrl_q,  wb_ctrl_d;
   logic [RA_W-1:0]   ex_rs_q,    ex_rs_d;
   logic [RA_W-1:0]   ex_rt_q,    ex_rt_d;
   logic [RA_W-1:0]   ex_rd_q,    ex_rd_d;
   logic [RA_W-1:0]   mem_dst_q,  mem_dst_d;
   logic [RA_W-1:0]   wb_dst_q,   wb_dst_d;

   logic [RA_W-1:0]   ex_dst;
   logic [CTRL_W-1:0] id_ctrl_s;
   logic              taken;
   logic              stall_hz;

   assign ex_dst = ex_ctrl_q[B_REGDST] ? ex_rd_q : ex_rt_q;
   assign taken  = ex_ctrl_q[B_BRANCH] & ex_zero;

   hazard_detect #(
      .RA_W (RA_W)
   ) u_hazard (
      .id_valid     (id_valid),
      .id_jump      (id_ctrl[B_JUMP]),
      .id_alusrc    (id_ctrl[B_ALUSRC]),
      .id_memwrite  (id_ctrl[B_MEMWRITE]),
      .id_branch    (id_ctrl[B_BRANCH]),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .ex_regwrite  (ex_ctrl_q[B_REGWRITE]),
      .ex_memread   (ex_ctrl_q[B_MEMREAD]),
      .ex_dst       (ex_dst),
      .ex_rs        (ex_rs_q),
      .ex_rt        (ex_rt_q),
      .mem_regwrite (mem_ctrl_q[B_REGWRITE]),
      .mem_dst      (mem_dst_q),
      .wb_regwrite  (wb_ctrl_q[B_REGWRITE]),
      .wb_dst       (wb_dst_q),
      .stall        (stall_hz),
      .fwd_a        (fwd_a),
      .fwd_b        (fwd_b)
   );

   always_comb begin
      // The decoder leaves ALUOp undefined for jumps; pin it so X never enters ID/EX.
      id_ctrl_s = id_ctrl;
      if (id_ctrl[B_JUMP]) begin
         id_ctrl_s[B_ALUOP_HI:B_ALUOP_LO] = ALUOP_ADD;
      end

      ex_ctrl_d = id_ctrl_s;
      ex_rs_d   = id_rs;
      ex_rt_d   = id_rt;
      ex_rd_d   = id_rd;
      // Taken branch, hazard stall or empty ID all insert a bubble; tags are
      // cleared too so a bubble can never look like a forwarding consumer.
      if (taken || stall_hz || !id_valid) begin
         ex_ctrl_d = BUBBLE;
         ex_rs_d   = '0;
         ex_rt_d   = '0;
         ex_rd_d   = '0;
      end

      mem_ctrl_d = ex_ctrl_q;
      mem_dst_d  = ex_dst;
      wb_ctrl_d  = mem_ctrl_q;
      wb_dst_d   = mem_dst_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_ctrl_q  <= BUBBLE;
         mem_ctrl_q <= BUBBLE;
         wb_ctrl_q  <= BUBBLE;
         ex_rs_q    <= '0;
         ex_rt_q    <= '0;
         ex_rd_q    <= '0;
         mem_dst_q  <= '0;
         wb_dst_q   <= '0;
      end else begin
         ex_ctrl_q  <= ex_ctrl_d;
         mem_ctrl_q <= mem_ctrl_d;
         wb_ctrl_q  <= wb_ctrl_d;
         ex_rs_q    <= ex_rs_d;
         ex_rt_q    <= ex_rt_d;
         ex_rd_q    <= ex_rd_d;
         mem_dst_q  <= mem_dst_d;
         wb_dst_q   <= wb_dst_d;
      end
   end

   assign ex_ctrl  = ex_ctrl_q;
   assign mem_ctrl = mem_ctrl_q;
   assign wb_ctrl  = wb_ctrl_q;
   assign ex_rs    = ex_rs_q;
   assign ex_rt    = ex_rt_q;
   assign mem_dst  = mem_dst_q;
   assign wb_dst   = wb_dst_q;

   // A taken branch kills the ID instruction, so holding it would be pointless.
   assign stall      = stall_hz & ~taken;
   assign flush_ifid = taken | (id_valid & id_ctrl[B_JUMP]);

endmodule

// File: tb/tb_ctrl_pipeline.sv
// tb/tb_ctrl_pipeline.sv - self-checking bench for ctrl_pipeline
//
// Purpose: drives instruction vectors into ID, checks stall/flush/forwarding
//   each cycle against the table and stage registers against a scoreboard.
//   Expected hazard columns follow CTRL_FWD_EN.
// Ports: none (top-level bench).
module tb_ctrl_pipeline;

   localparam logic [10:0] BUB   = 11'h001;
   localparam logic [10:0] C_R   = 11'h480;
   localparam logic [10:0] C_ADI = 11'h289;
   localparam logic [10:0] C_LW  = 11'h38D;
   localparam logic [10:0] C_SW  = 11'h249;
   localparam logic [10:0] C_BEQ = 11'h022;
   localparam logic [10:0] C_J   = 11'h013;
   localparam logic [10:0] C_J2  = 11'h012;

   logic        clk;
   logic        rst;
   logic        id_valid;
   logic [10:0] id_ctrl;
   logic [4:0]  id_rs, id_rt, id_rd;
   logic        ex_zero;
   logic [10:0] ex_ctrl, mem_ctrl, wb_ctrl;
   logic [4:0]  ex_rs, ex_rt, mem_dst, wb_dst;
   logic        stall, flush_ifid;
   logic [1:0]  fwd_a, fwd_b;

   ctrl_pipeline #(.RA_W(5)) dut (
      .clk        (clk),
      .rst        (rst),
      .id_valid   (id_valid),
      .id_ctrl    (id_ctrl),
      .id_rs      (id_rs),
      .id_rt      (id_rt),
      .id_rd      (id_rd),
      .ex_zero    (ex_zero),
      .ex_ctrl    (ex_ctrl),
      .mem_ctrl   (mem_ctrl),
      .wb_ctrl    (wb_ctrl),
      .ex_rs      (ex_rs),
      .ex_rt      (ex_rt),
      .mem_dst    (mem_dst),
      .wb_dst     (wb_dst),
      .stall      (stall),
      .flush_ifid (flush_ifid),
      .fwd_a      (fwd_a),
      .fwd_b      (fwd_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        valid;
      logic [10:0] ctrl;
      logic [4:0]  rs, rt, rd;
      logic        zero;
      logic        stall, flush;
      logic [1:0]  fa, fb;
   } vec_t;

   typedef struct {
      logic [10:0] ex, mem, wb;
      logic [4:0]  mdst, wdst;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];

   int checks = 0;
   int errors = 0;

   logic [10:0] m_ex, m_mem, m_wb;
   logic [4:0]  m_ex_rt, m_ex_rd, m_mem_dst, m_wb_dst;

   function automatic vec_t mk(input logic v, input logic [10:0] c,
                               input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] rd, input logic z,
                               input logic st, input logic fl,
                               input logic [1:0] fa, input logic [1:0] fb);
      vec_t r;
      r.valid = v; r.ctrl = c; r.rs = rs; r.rt = rt; r.rd = rd; r.zero = z;
      r.stall = st; r.flush = fl; r.fa = fa; r.fb = fb;
      return r;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step(input string tag, input logic r, input vec_t v, input bit chk);
      exp_t e;
      logic tk;
      logic kill;
      rst      = r;
      id_valid = v.valid;
      id_ctrl  = v.ctrl;
      id_rs    = v.rs;
      id_rt    = v.rt;
      id_rd    = v.rd;
      ex_zero  = v.zero;
      #1;
      if (chk) begin
         check({tag, " stall"}, 32'(stall),      32'(v.stall));
         check({tag, " flush"}, 32'(flush_ifid), 32'(v.flush));
         check({tag, " fwd_a"}, 32'(fwd_a),      32'(v.fa));
         check({tag, " fwd_b"}, 32'(fwd_b),      32'(v.fb));
      end
      if (r) begin
         m_ex = BUB; m_mem = BUB; m_wb = BUB;
         m_ex_rt = '0; m_ex_rd = '0; m_mem_dst = '0; m_wb_dst = '0;
      end else begin
         tk   = m_ex[5] & v.zero;
         kill = tk | v.stall | ~v.valid;
         m_wb      = m_mem;
         m_wb_dst  = m_mem_dst;
         m_mem     = m_ex;
         m_mem_dst = m_ex[10] ? m_ex_rd : m_ex_rt;
         if (kill) begin
            m_ex = BUB; m_ex_rt = '0; m_ex_rd = '0;
         end else begin
            m_ex = v.ctrl;
            if (v.ctrl[4]) m_ex[1:0] = 2'b01;
            m_ex_rt = v.rt;
            m_ex_rd = v.rd;
         end
      end
      e.ex = m_ex; e.mem = m_mem; e.wb = m_wb; e.mdst = m_mem_dst; e.wdst = m_wb_dst;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check({tag, " ex_ctrl"},  32'(ex_ctrl),  32'(e.ex));
      check({tag, " mem_ctrl"}, 32'(mem_ctrl), 32'(e.mem));
      check({tag, " wb_ctrl"},  32'(wb_ctrl),  32'(e.wb));
      check({tag, " mem_dst"},  32'(mem_dst),  32'(e.mdst));
      check({tag, " wb_dst"},   32'(wb_dst),   32'(e.wdst));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t idle, v;
      m_ex = BUB; m_mem = BUB; m_wb = BUB;
      m_ex_rt = '0; m_ex_rd = '0; m_mem_dst = '0; m_wb_dst = '0;

`ifdef CTRL_FWD_EN
      tbl.push_back(mk(1, C_ADI, 0, 5, 0, 0, 0, 0, 2'b00, 2'b00)); // addi $5
      tbl.push_back(mk(1, C_R,   5, 5, 6, 0, 0, 0, 2'b00, 2'b00)); // sub $6,$5,$5
      tbl.push_back(mk(1, C_LW,  0, 2, 0, 0, 0, 0, 2'b10, 2'b10)); // lw $2; sub forwards EX/MEM
      tbl.push_back(mk(1, C_R,   2, 4, 3, 0, 1, 0, 2'b00, 2'b00)); // add $3,$2,$4 load-use
      tbl.push_back(mk(1, C_R,   2, 4, 3, 0, 0, 0, 2'b00, 2'b00)); // add retried
      tbl.push_back(mk(1, C_BEQ, 8, 9, 0, 0, 0, 0, 2'b01, 2'b00)); // beq; add gets $2 from WB
      tbl.push_back(mk(1, C_R,   3, 0, 1, 1, 0, 1, 2'b00, 2'b00)); // beq taken
      tbl.push_back(mk(1, C_J,   0, 0, 0, 0, 0, 1, 2'b00, 2'b00)); // j
      tbl.push_back(mk(1, C_ADI, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00)); // addi $0, zero w/o branch
      tbl.push_back(mk(1, C_R,   0, 0, 7, 0, 0, 0, 2'b00, 2'b00)); // reader of $0
      tbl.push_back(mk(0, C_R,   7, 7, 7, 0, 0, 0, 2'b00, 2'b00)); // invalid
      tbl.push_back(mk(1, C_SW,  0, 7, 0, 0, 0, 0, 2'b00, 2'b00)); // sw $7
      tbl.push_back(mk(0, 11'h0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01)); // sw rt from WB
`else
      tbl.push_back(mk(1, C_ADI, 0, 5, 0, 0, 0, 0, 2'b00, 2'b00)); // addi $5
      tbl.push_back(mk(1, C_R,   5, 5, 6, 0, 1, 0, 2'b00, 2'b00)); // sub: EX hazard
      tbl.push_back(mk(1, C_R,   5, 5, 6, 0, 1, 0, 2'b00, 2'b00)); // sub: MEM hazard
      tbl.push_back(mk(1, C_R,   5, 5, 6, 0, 0, 0, 2'b00, 2'b00)); // sub proceeds
      tbl.push_back(mk(1, C_LW,  0, 2, 0, 0, 0, 0, 2'b00, 2'b00)); // lw $2
      tbl.push_back(mk(1, C_R,   2, 4, 3, 0, 1, 0, 2'b00, 2'b00)); // add $3,$2,$4
      tbl.push_back(mk(1, C_R,   2, 4, 3, 0, 1, 0, 2'b00, 2'b00));
      tbl.push_back(mk(1, C_R,   2, 4, 3, 0, 0, 0, 2'b00, 2'b00));
      tbl.push_back(mk(1, C_BEQ, 8, 9, 0, 0, 0, 0, 2'b00, 2'b00)); // beq
      tbl.push_back(mk(1, C_R,   3, 0, 1, 1, 0, 1, 2'b00, 2'b00)); // taken over hazard
      tbl.push_back(mk(1, C_J,   0, 0, 0, 0, 0, 1, 2'b00, 2'b00)); // j
      tbl.push_back(mk(1, C_ADI, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00)); // addi $0, zero w/o branch
      tbl.push_back(mk(1, C_R,   0, 0, 7, 0, 0, 0, 2'b00, 2'b00)); // reader of $0
      tbl.push_back(mk(0, C_R,   7, 7, 7, 0, 0, 0, 2'b00, 2'b00)); // invalid
      tbl.push_back(mk(1, C_SW,  0, 7, 0, 0, 1, 0, 2'b00, 2'b00)); // sw $7: MEM hazard
`endif

      idle = mk(0, 11'h0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
      step("rst0", 1'b1, idle, 1'b0);
      step("rst1", 1'b1, idle, 1'b1);

      for (int i = 0; i < tbl.size(); i++) begin
         step($sformatf("row%0d", i), 1'b0, tbl[i], 1'b1);
      end

      // Reset in mid-stream, with an ID instruction that would otherwise hazard.
      step("mid_lw",   1'b0, mk(1, C_LW,  0, 2, 0, 0, 0, 0, 2'b00, 2'b00), 1'b1);
      step("mid_addi", 1'b0, mk(1, C_ADI, 0, 9, 0, 0, 0, 0, 2'b00, 2'b00), 1'b1);
      v = mk(1, C_R, 2, 9, 1, 0, 0, 0, 2'b00, 2'b00);
      step("mrst0", 1'b1, v, 1'b0);
      step("mrst1", 1'b1, v, 1'b1);
      step("post_rst", 1'b0, v, 1'b1);
      // Jump with a different ALUOp pattern still lands as ALUOp=01.
      step("j2", 1'b0, mk(1, C_J2, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00), 1'b1);
      check("j2 ex_aluop", 32'(ex_ctrl[1:0]), 32'(2'b01));
      check("j2 ex_jump",  32'(ex_ctrl[4]),   32'(1'b1));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
